// File: rtl/mem_seq.sv
// Memory-port sequencer: shares one word-addressed data memory between fetch and load/store,
// drives the dataconv converter, and runs sub-word stores as read-modify-write. Macro: MEM_SEQ_RR_EN.
module mem_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [29:0] if_addr,
   output logic        if_ack,
   output logic [31:0] if_rdata,
   input  logic        ls_req,
   input  logic        ls_rw,
   input  logic [2:0]  ls_func,
   input  logic [31:0] ls_base,
   input  logic [15:0] ls_offset,
   input  logic [31:0] ls_rreg,
   output logic        ls_ack,
   output logic [31:0] ls_out,
   output logic [31:0] cv_base,
   output logic [15:0] cv_offset,
   output logic [2:0]  cv_func,
   output logic        cv_rw,
   output logic [31:0] cv_rin,
   output logic [31:0] cv_din,
   input  logic [31:0] cv_out,
   input  logic [29:0] cv_addr,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   typedef enum logic [2:0] {IDLE, FETCH, LREAD, SREAD, SWRITE, UIMM} state_t;

   localparam logic [2:0] F_B  = 3'd0;
   localparam logic [2:0] F_H  = 3'd1;
   localparam logic [2:0] F_WL = 3'd2;
   localparam logic [2:0] F_WR = 3'd6;
   localparam logic [2:0] F_UI = 3'd7;

   state_t      state;
   logic [31:0] mbuf;
   logic        grant_ls;
   logic        grant_if;
   logic        ls_rmw;
   logic        ack_busy;

   assign cv_base   = ls_base;
   assign cv_offset = ls_offset;
   assign cv_func   = ls_func;
   assign cv_rw     = ls_rw;
   assign cv_rin    = ls_rreg;
   assign cv_din    = mbuf;

   assign mem_addr  = (state == FETCH) ? if_addr : cv_addr;

   // Only byte, half and unaligned-word stores need the old word; bu/hu stores fall through as full words.
   assign ls_rmw    = (ls_func == F_B) || (ls_func == F_H) || (ls_func == F_WL) || (ls_func == F_WR);

   // The requester still holds req during its ack cycle, so no grant is made while an ack is visible.
   assign ack_busy  = if_ack || ls_ack;

`ifdef MEM_SEQ_RR_EN
   logic rr_ptr;
   assign grant_ls = ls_req && (!if_req || !rr_ptr);
`else
   assign grant_ls = ls_req;
`endif
   assign grant_if = if_req && !grant_ls;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         mbuf      <= '0;
         if_ack    <= 1'b0;
         if_rdata  <= '0;
         ls_ack    <= 1'b0;
         ls_out    <= '0;
`ifdef MEM_SEQ_RR_EN
         rr_ptr    <= 1'b0;
`endif
      end else begin
         // NOTE: acks default low here and are raised below, giving single-cycle pulses without extra state.
         if_ack <= 1'b0;
         ls_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (!ack_busy) begin
`ifdef MEM_SEQ_RR_EN
                  if (ls_req && if_req) rr_ptr <= grant_ls;
`endif
                  if (grant_ls) begin
                     if (ls_func == F_UI) begin
                        ls_out <= {ls_offset, 16'h0000};
                        ls_ack <= 1'b1;
                        state  <= UIMM;
                     end else if (!ls_rw) begin
                        mem_req <= 1'b1;
                        state   <= LREAD;
                     end else if (ls_rmw) begin
                        mem_req <= 1'b1;
                        state   <= SREAD;
                     end else begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_wdata <= ls_rreg;
                        state     <= SWRITE;
                     end
                  end else if (grant_if) begin
                     mem_req <= 1'b1;
                     state   <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (mem_ack) begin
                  if_rdata <= mem_rdata;
                  if_ack   <= 1'b1;
                  mem_req  <= 1'b0;
                  state    <= IDLE;
               end
            end
            // LREAD and SREAD use mem_req as their phase: high while reading, low for the converter cycle.
            LREAD: begin
               if (mem_req) begin
                  if (mem_ack) begin
                     mbuf    <= mem_rdata;
                     mem_req <= 1'b0;
                  end
               end else begin
                  ls_out <= cv_out;
                  ls_ack <= 1'b1;
                  state  <= IDLE;
               end
            end
            SREAD: begin
               if (mem_req) begin
                  if (mem_ack) begin
                     mbuf    <= mem_rdata;
                     mem_req <= 1'b0;
                  end
               end else begin
                  mem_wdata <= cv_out;
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  state     <= SWRITE;
               end
            end
            SWRITE: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  ls_ack  <= 1'b1;
                  state   <= IDLE;
               end
            end
            UIMM: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_seq.sv
// Directed self-checking bench for mem_seq with a variable-latency memory and a little-endian
// dataconv stand-in; arbitration expectations follow MEM_SEQ_RR_EN.
module tb_mem_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [29:0] if_addr;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        ls_req;
   logic        ls_rw;
   logic [2:0]  ls_func;
   logic [31:0] ls_base;
   logic [15:0] ls_offset;
   logic [31:0] ls_rreg;
   logic        ls_ack;
   logic [31:0] ls_out;
   logic [31:0] cv_base;
   logic [15:0] cv_offset;
   logic [2:0]  cv_func;
   logic        cv_rw;
   logic [31:0] cv_rin;
   logic [31:0] cv_din;
   logic [31:0] cv_out;
   logic [29:0] cv_addr;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_seq dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .ls_req(ls_req), .ls_rw(ls_rw), .ls_func(ls_func), .ls_base(ls_base),
      .ls_offset(ls_offset), .ls_rreg(ls_rreg), .ls_ack(ls_ack), .ls_out(ls_out),
      .cv_base(cv_base), .cv_offset(cv_offset), .cv_func(cv_func), .cv_rw(cv_rw),
      .cv_rin(cv_rin), .cv_din(cv_din), .cv_out(cv_out), .cv_addr(cv_addr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   // Little-endian converter stand-in
   logic [31:0] cv_ea;
   logic [7:0]  cv_byte;
   logic [15:0] cv_half;
   always_comb begin
      cv_ea   = cv_base + {{16{cv_offset[15]}}, cv_offset};
      cv_addr = cv_ea[31:2];
      cv_byte = cv_din[cv_ea[1:0]*8 +: 8];
      cv_half = cv_ea[1] ? cv_din[31:16] : cv_din[15:0];
      cv_out  = cv_din;
      if (!cv_rw) begin
         case (cv_func)
            3'd0: cv_out = {{24{cv_byte[7]}}, cv_byte};
            3'd1: cv_out = {{16{cv_half[15]}}, cv_half};
            3'd4: cv_out = {24'h0, cv_byte};
            3'd5: cv_out = {16'h0, cv_half};
            3'd7: cv_out = {cv_offset, 16'h0000};
            default: cv_out = cv_din;
         endcase
      end else begin
         case (cv_func)
            3'd0: cv_out[cv_ea[1:0]*8 +: 8] = cv_rin[7:0];
            3'd1: cv_out[cv_ea[1]*16 +: 16] = cv_rin[15:0];
            default: cv_out = cv_rin;
         endcase
      end
   end

   // Variable-latency memory: ack arrives lat cycles after mem_req rises
   logic [31:0] mem [0:1023];
   int          lat = 0;
   int          cnt = 0;
   logic        pl_we = 1'b0;
   logic [9:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;
   int          rd_count = 0;
   int          wr_count = 0;
   int          req_cycles = 0;
   logic [29:0] last_rd_addr = '0;
   logic [29:0] last_wr_addr = '0;
   logic [31:0] last_wr_data = '0;

   assign mem_ack   = mem_req && (cnt == lat);
   assign mem_rdata = mem[mem_addr[9:0]];

   always @(posedge clk) begin
      if (!mem_req || mem_ack) cnt <= 0;
      else cnt <= cnt + 1;
      if (mem_req) req_cycles <= req_cycles + 1;
      if (pl_we) mem[pl_addr] <= pl_data;
      if (mem_req && mem_ack) begin
         if (mem_we) begin
            mem[mem_addr[9:0]] <= mem_wdata;
            wr_count     <= wr_count + 1;
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wdata;
         end else begin
            rd_count     <= rd_count + 1;
            last_rd_addr <= mem_addr;
         end
      end
   end

   task automatic preload(input logic [9:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_addr = a;
      pl_data = d;
      pl_we   = 1'b1;
      @(negedge clk);
      pl_we   = 1'b0;
   endtask

   // Request raised in cycle 0; cyc is the cycle in which ls_ack is seen
   task automatic run_ls(input logic rw, input logic [2:0] func, input logic [31:0] base,
                         input logic [15:0] off, input logic [31:0] rreg, output int cyc);
      @(negedge clk);
      ls_rw = rw; ls_func = func; ls_base = base; ls_offset = off; ls_rreg = rreg;
      ls_req = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!ls_ack && cyc < 40);
      ls_req = 1'b0;
      if (!ls_ack) begin
         checks++; errors++;
         $display("FAIL ls_timeout: no ls_ack, required within 40 cycles");
         cyc = -1;
      end
   endtask

   task automatic test_reset;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", mem_req); end
      checks++;
      if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", mem_we); end
      checks++;
      if (if_ack !== 1'b0 || ls_ack !== 1'b0) begin errors++; $display("FAIL rst_acks got %b%b exp 00", if_ack, ls_ack); end
      checks++;
      if (if_rdata !== 32'h0) begin errors++; $display("FAIL rst_if_rdata got %h exp 0", if_rdata); end
      checks++;
      if (ls_out !== 32'h0) begin errors++; $display("FAIL rst_ls_out got %h exp 0", ls_out); end
      checks++;
      if (mem_wdata !== 32'h0) begin errors++; $display("FAIL rst_mem_wdata got %h exp 0", mem_wdata); end
      checks++;
      if (cv_din !== 32'h0) begin errors++; $display("FAIL rst_mbuf got %h exp 0", cv_din); end
      checks++;
   endtask

   task automatic test_fetch;
      int cyc;
      int rd0;
      preload(10'h100, 32'h24080005);
      lat = 0;
      rd0 = rd_count;
      @(negedge clk);
      if_addr = 30'h100;
      if_req  = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!if_ack && cyc < 40);
      if_req = 1'b0;
      if (cyc !== 2) begin errors++; $display("FAIL fetch_latency got %0d exp 2", cyc); end
      checks++;
      if (if_rdata !== 32'h24080005) begin errors++; $display("FAIL fetch_rdata got %h exp 24080005", if_rdata); end
      checks++;
      if (last_rd_addr !== 30'h100) begin errors++; $display("FAIL fetch_addr got %h exp 100", last_rd_addr); end
      checks++;
      if (rd_count - rd0 !== 1) begin errors++; $display("FAIL fetch_reads got %0d exp 1", rd_count - rd0); end
      checks++;
   endtask

   task automatic test_load;
      int cyc;
      preload(10'h100 << 2, 32'h80FF1122);
      lat = 0;
      run_ls(1'b0, 3'd0, 32'h1000, 16'd3, 32'h0, cyc);
      if (cyc !== 3) begin errors++; $display("FAIL lb_latency got %0d exp 3", cyc); end
      checks++;
      if (ls_out !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_out got %h exp ffffff80", ls_out); end
      checks++;
      if (last_rd_addr !== 30'h400) begin errors++; $display("FAIL lb_addr got %h exp 400", last_rd_addr); end
      checks++;
      preload(10'h001, 32'h80017FFF);
      preload(10'h001, 32'h80017FFF);
      run_ls(1'b0, 3'd1, 32'h4, 16'd2, 32'h0, cyc);
      if (ls_out !== 32'hFFFF8001) begin errors++; $display("FAIL lh_out got %h exp ffff8001", ls_out); end
      checks++;
      run_ls(1'b0, 3'd5, 32'h4, 16'd2, 32'h0, cyc);
      if (ls_out !== 32'h00008001) begin errors++; $display("FAIL lhu_out got %h exp 00008001", ls_out); end
      checks++;
      run_ls(1'b0, 3'd1, 32'h8, 16'hFFFC, 32'h0, cyc);
      if (ls_out !== 32'h00007FFF) begin errors++; $display("FAIL lh_neg_off got %h exp 00007fff", ls_out); end
      checks++;
   endtask

   task automatic test_store;
      int cyc;
      int rd0;
      int wr0;
      preload(10'h000, 32'h11223344);
      lat = 0;
      rd0 = rd_count;
      wr0 = wr_count;
      run_ls(1'b1, 3'd0, 32'h1000, 16'd1, 32'h000000AB, cyc);
      if (cyc !== 4) begin errors++; $display("FAIL sb_latency got %0d exp 4", cyc); end
      checks++;
      if (rd_count - rd0 !== 1 || wr_count - wr0 !== 1) begin
         errors++; $display("FAIL sb_accesses got rd %0d wr %0d exp rd 1 wr 1", rd_count - rd0, wr_count - wr0);
      end
      checks++;
      if (last_wr_addr !== 30'h400) begin errors++; $display("FAIL sb_addr got %h exp 400", last_wr_addr); end
      checks++;
      if (last_wr_data !== 32'h1122AB44) begin errors++; $display("FAIL sb_wdata got %h exp 1122ab44", last_wr_data); end
      checks++;
      preload(10'h000, 32'hAABBCCDD);
      lat = 1;
      run_ls(1'b1, 3'd1, 32'h1000, 16'd2, 32'h0000BEEF, cyc);
      if (cyc !== 6) begin errors++; $display("FAIL sh_latency got %0d exp 6", cyc); end
      checks++;
      if (mem[0] !== 32'hBEEFCCDD) begin errors++; $display("FAIL sh_mem got %h exp beefccdd", mem[0]); end
      checks++;
      lat = 2;
      run_ls(1'b1, 3'd3, 32'h200, 16'hFFFC, 32'hDEADBEEF, cyc);
      if (cyc !== 4) begin errors++; $display("FAIL sw_latency got %0d exp 4", cyc); end
      checks++;
      if (last_wr_addr !== 30'h07F || mem[10'h07F] !== 32'hDEADBEEF) begin
         errors++; $display("FAIL sw_mem got addr %h data %h exp 07f deadbeef", last_wr_addr, mem[10'h07F]);
      end
      checks++;
      lat = 0;
      rd0 = rd_count;
      run_ls(1'b1, 3'd4, 32'h300, 16'd0, 32'h01020304, cyc);
      if (cyc !== 2 || rd_count - rd0 !== 0) begin
         errors++; $display("FAIL sbu_as_word got cyc %0d reads %0d exp cyc 2 reads 0", cyc, rd_count - rd0);
      end
      checks++;
      if (mem[10'h0C0] !== 32'h01020304) begin errors++; $display("FAIL sbu_mem got %h exp 01020304", mem[10'h0C0]); end
      checks++;
   endtask

   task automatic test_lui;
      int cyc;
      int rq0;
      rq0 = req_cycles;
      run_ls(1'b0, 3'd7, 32'h0, 16'h1234, 32'h0, cyc);
      if (cyc !== 1) begin errors++; $display("FAIL lui_latency got %0d exp 1", cyc); end
      checks++;
      if (ls_out !== 32'h12340000) begin errors++; $display("FAIL lui_out got %h exp 12340000", ls_out); end
      checks++;
      if (req_cycles - rq0 !== 0) begin errors++; $display("FAIL lui_no_mem got %0d req cycles exp 0", req_cycles - rq0); end
      checks++;
   endtask

   task automatic test_back_to_back;
`ifdef MEM_SEQ_RR_EN
      logic [3:0] exp_ls = 4'b0101;
`else
      logic [3:0] exp_ls = 4'b1111;
`endif
      int n;
      lat = 0;
      @(negedge clk);
      if_addr = 30'h100;
      ls_rw = 1'b0; ls_func = 3'd3; ls_base = 32'h800; ls_offset = 16'd0; ls_rreg = 32'h0;
      if_req = 1'b1;
      ls_req = 1'b1;
      for (int g = 0; g < 5; g++) begin
         if (g == 4) ls_req = 1'b0;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!(ls_ack || if_ack) && n < 40);
         if (g < 4) begin
            if (ls_ack !== exp_ls[g] || if_ack !== !exp_ls[g]) begin
               errors++; $display("FAIL arb_grant%0d got ls %b if %b exp ls %b", g, ls_ack, if_ack, exp_ls[g]);
            end
         end else begin
            if (if_ack !== 1'b1) begin errors++; $display("FAIL arb_after_ls_drop got if_ack %b exp 1", if_ack); end
         end
         checks++;
      end
      if_req = 1'b0;
   endtask

   task automatic test_reset_mid;
      int cyc;
      int wr0;
      int acks;
      lat = 3;
      wr0 = wr_count;
      @(negedge clk);
      ls_rw = 1'b1; ls_func = 3'd0; ls_base = 32'h1000; ls_offset = 16'd0; ls_rreg = 32'h55;
      ls_req = 1'b1;
      repeat (2) @(negedge clk);
      if (mem_req !== 1'b1 || mem_we !== 1'b0) begin
         errors++; $display("FAIL sread_req got req %b we %b exp 1 0", mem_req, mem_we);
      end
      checks++;
      rst = 1'b1;
      ls_req = 1'b0;
      @(negedge clk);
      if (mem_req !== 1'b0 || mem_we !== 1'b0 || ls_ack !== 1'b0) begin
         errors++; $display("FAIL rst_mid got req %b we %b ack %b exp 0 0 0", mem_req, mem_we, ls_ack);
      end
      checks++;
      rst = 1'b0;
      acks = 0;
      repeat (6) begin
         @(negedge clk);
         if (ls_ack || mem_req) acks++;
      end
      if (acks !== 0 || wr_count - wr0 !== 0) begin
         errors++; $display("FAIL rst_abandon got activity %0d writes %0d exp 0 0", acks, wr_count - wr0);
      end
      checks++;
      lat = 0;
      run_ls(1'b1, 3'd3, 32'h1000, 16'd0, 32'h600DF00D, cyc);
      if (cyc !== 2) begin errors++; $display("FAIL post_rst_sw_latency got %0d exp 2", cyc); end
      checks++;
      if (mem[0] !== 32'h600DF00D) begin errors++; $display("FAIL post_rst_sw_mem got %h exp 600df00d", mem[0]); end
      checks++;
   endtask

   initial begin
      rst = 1'b1;
      if_req = 1'b0; if_addr = '0;
      ls_req = 1'b0; ls_rw = 1'b0; ls_func = '0; ls_base = '0; ls_offset = '0; ls_rreg = '0;
      repeat (3) @(negedge clk);
      test_reset;
      rst = 1'b0;
      test_fetch;
      test_load;
      test_store;
      test_lui;
      test_back_to_back;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
